// File: rtl/wb_arbiter.sv
// Registered multi-source writeback stage: per-source in-order buffers drained
// one result per cycle by a round-robin arbiter into a flopped RF write port.
module wb_arbiter #(
    parameter int unsigned NUM_SRC        = 3,
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned BUF_DEPTH      = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_SRC-1:0]                  src_vld,
    output logic [NUM_SRC-1:0]                  src_rdy,
    input  logic [NUM_SRC-1:0]                  src_rd_we,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]   src_rd_addr,
    input  logic [NUM_SRC*REG_WIDTH-1:0]        src_rd,
    output logic                                rf_rd_we,
    output logic [REG_ADDR_WIDTH-1:0]           rf_rd_addr,
    output logic [REG_WIDTH-1:0]                rf_rd,
    output logic                                wb_idle
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [REG_ADDR_WIDTH-1:0] buf_addr_q [NUM_SRC][BUF_DEPTH];
    logic [REG_WIDTH-1:0]      buf_data_q [NUM_SRC][BUF_DEPTH];
    logic [PtrW-1:0]           wr_ptr_q [NUM_SRC];
    logic [PtrW-1:0]           wr_ptr_d [NUM_SRC];
    logic [PtrW-1:0]           rd_ptr_q [NUM_SRC];
    logic [PtrW-1:0]           rd_ptr_d [NUM_SRC];
    logic [CntW-1:0]           cnt_q    [NUM_SRC];
    logic [CntW-1:0]           cnt_d    [NUM_SRC];
    logic [SrcW-1:0]           rr_q, rr_d;

    logic [NUM_SRC-1:0]        push, pop, full, empty;
    logic                      gnt_vld;
    logic [SrcW-1:0]           gnt_idx;
    logic [REG_ADDR_WIDTH-1:0] head_addr;
    logic [REG_WIDTH-1:0]      head_data;

    logic                      rf_we_q, rf_we_d;
    logic [REG_ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [REG_WIDTH-1:0]      rf_data_q, rf_data_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Ready depends only on registered occupancy; filtered transfers still handshake.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            full[i]  = (cnt_q[i] == CntW'(BUF_DEPTH));
            empty[i] = (cnt_q[i] == '0);
            push[i]  = src_vld[i] & ~full[i] & src_rd_we[i] &
                       (src_rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] != '0);
        end
    end

    assign src_rdy = ~full;

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (32'(rr_q) + k) % NUM_SRC;
            if (!gnt_vld && !empty[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SrcW'(idx);
            end
        end
        pop       = gnt_vld ? (NUM_SRC'(1) << gnt_idx) : '0;
        head_addr = buf_addr_q[gnt_idx][rd_ptr_q[gnt_idx]];
        head_data = buf_data_q[gnt_idx][rd_ptr_q[gnt_idx]];
        rr_d      = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_idx == SrcW'(NUM_SRC - 1)) ? '0 : gnt_idx + SrcW'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    // Datapath is gated to zero on idle cycles.
    always_comb begin
        rf_we_d   = gnt_vld;
        rf_addr_d = gnt_vld ? head_addr : '0;
        rf_data_d = gnt_vld ? head_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_q      <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rr_q      <= rr_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                buf_addr_q[i][wr_ptr_q[i]] <= src_rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
                buf_data_q[i][wr_ptr_q[i]] <= src_rd[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign rf_rd_we   = rf_we_q;
    assign rf_rd_addr = rf_addr_q;
    assign rf_rd      = rf_data_q;
    assign wb_idle    = ~rf_we_q & (&empty);

endmodule
